// File: rtl/layer_sequencer.sv
// layer_sequencer: drives one fully-connected layer of neuron MAC units
// through a complete pass. The pass runs CLEAR -> FEED -> DRAIN -> WRITE -> DONE:
// it clears the accumulators, streams the activations and weights, lets the MAC
// pipeline settle, then writes the N_OUT results serially into the next layer's
// activation RAM.
// Optional feature macro: LAYER_SEQ_RELU_EN. When it is defined, negative
// results are written as zero (ReLU). When it is undefined, results pass
// through unchanged, which is what the output layer feeding argmax needs.
// Pass timing is the same in both builds.
module layer_sequencer #(
    parameter int N_IN    = 784,
    parameter int N_OUT   = 20,
    parameter int MAC_LAT = 3
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Start,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(N_IN)-1:0]  X_addr,
    input  logic [15:0]              X_data,
    output logic [$clog2(N_IN)-1:0]  W_addr,
    input  logic [16*N_OUT-1:0]      W_data,
    output logic                     Active,
    output logic [15:0]              X,
    output logic [16*N_OUT-1:0]      W,
    input  logic [16*N_OUT-1:0]      Z,
    output logic                     Y_we,
    output logic [$clog2(N_OUT)-1:0] Y_addr,
    output logic [15:0]              Y_data
);

    localparam int DATA_W  = 16;
    localparam int AW      = $clog2(N_IN);
    localparam int YW      = $clog2(N_OUT);
    // One phase counter serves CLEAR, FEED and DRAIN, so it is sized for the longest.
    localparam int CNT_LIM = (N_IN > MAC_LAT) ? N_IN : MAC_LAT;
    localparam int CW      = $clog2(CNT_LIM + 1);

    localparam logic [CW-1:0] LAT_LAST  = CW'(MAC_LAT);
    localparam logic [CW-1:0] FEED_LAST = CW'(N_IN);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N_IN - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [YW-1:0] Y_LAST    = YW'(N_OUT - 1);
    localparam logic [YW-1:0] Y_ONE     = YW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic                      busy_r;
    logic                      done_r;
    logic                      active_r;
    logic                      opnd_vld_p0;
    logic [AW-1:0]             addr_r;
    logic                      y_we_r;
    logic [YW-1:0]             y_addr_r;
    logic                      cap_en;
    logic signed [DATA_W-1:0]  z_cap [N_OUT];

    // ReLU when the feature is built in, otherwise a straight pass-through.
    function automatic logic signed [DATA_W-1:0] rectify(input logic signed [DATA_W-1:0] v);
`ifdef LAYER_SEQ_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Pass FSM; every control output is a flop loaded with its next-cycle value.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            active_r    <= 1'b0;
            opnd_vld_p0 <= 1'b0;
            addr_r      <= '0;
            y_we_r      <= 1'b0;
            y_addr_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state  <= S_CLEAR;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                // Active stays low for MAC_LAT+1 cycles so every pipeline stage sees the clear.
                S_CLEAR: begin
                    if (cnt == LAT_LAST) begin
                        state  <= S_FEED;
                        cnt    <= '0;
                        addr_r <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                // Cycle 0 only issues address 0; each later cycle forwards the word read one cycle earlier.
                S_FEED: begin
                    active_r <= 1'b1;
                    if (cnt == FEED_LAST) begin
                        state       <= S_DRAIN;
                        cnt         <= '0;
                        opnd_vld_p0 <= 1'b0;
                        addr_r      <= '0;
                    end else begin
                        cnt         <= cnt + CNT_ONE;
                        opnd_vld_p0 <= 1'b1;
                        addr_r      <= (addr_r == ADDR_LAST) ? '0 : addr_r + ADDR_ONE;
                    end
                end
                // Zero operands keep accumulating nothing while the last products reach Z.
                S_DRAIN: begin
                    if (cnt == LAT_LAST) begin
                        state    <= S_WRITE;
                        cnt      <= '0;
                        active_r <= 1'b0;
                        y_we_r   <= 1'b1;
                        y_addr_r <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WRITE: begin
                    if (y_addr_r == Y_LAST) begin
                        state    <= S_DONE;
                        y_we_r   <= 1'b0;
                        y_addr_r <= '0;
                        done_r   <= 1'b1;
                    end else begin
                        y_addr_r <= y_addr_r + Y_ONE;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    busy_r   <= 1'b0;
                    active_r <= 1'b0;
                    y_we_r   <= 1'b0;
                end
            endcase
        end
    end

    assign cap_en = (state == S_DRAIN) && (cnt == LAT_LAST);

    // Snapshot all neuron results on the last DRAIN cycle, before WRITE lets the accumulators clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                z_cap[j] <= '0;
            end
        end else if (cap_en) begin
            for (int j = 0; j < N_OUT; j++) begin
                z_cap[j] <= $signed(Z[DATA_W*j +: DATA_W]);
            end
        end
    end

    assign Busy   = busy_r;
    assign Done   = done_r;
    assign Active = active_r;
    assign X_addr = addr_r;
    assign W_addr = addr_r;
    // The memory read data is forwarded only in FEED cycles 1..N_IN; zero everywhere else.
    assign X      = opnd_vld_p0 ? X_data : '0;
    assign W      = opnd_vld_p0 ? W_data : '0;
    assign Y_we   = y_we_r;
    assign Y_addr = y_addr_r;
    assign Y_data = y_we_r ? rectify(z_cap[y_addr_r]) : '0;

endmodule
